crc32_check_cfu: RTL
====================

Name: crc32_check_cfu

Overview:
- Stateful CRC-32 custom function unit: accumulates a running CRC over bytes or words streamed from the core.
- Checker/receiver side of the CRC path: after a frame and its appended CRC are fed in, a CHECK op reports whether the residue matches.
- Sits behind the core's CFU request/response handshake.
- Byte-serial table-lookup datapath: one byte per clock.

Parameters:
- POLY, 32'hEDB88320: reflected CRC polynomial. The 256x32 lookup table is generated from POLY at elaboration by a constant function; no external hex file.
- INIT_VAL, 32'hFFFFFFFF: value loaded into crc_reg by reset and by INIT.
- FINAL_XOR, 32'hFFFFFFFF: XOR applied to crc_reg when it is returned.
- RESIDUE, 32'hDEBB20E3: crc_reg value that indicates a good frame+CRC.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request.
- req_function_id  in  3  0=INIT, 1=BYTE, 2=WORD, 3=CHECK, 4=READ, 5-7 reserved.
- req_data0  in  32  operand: byte in [7:0] for BYTE; 4 bytes, LSB first, for WORD.
- resp_valid  out  1  response present.
- resp_ready  in  1  core accepts the response.
- resp_data  out  32  result.
- busy  out  1  high in BUSY or RESP.

Behaviour:
- Reset (rst low, asynchronous):
  - state=IDLE, crc_reg=INIT_VAL.
  - req_ready=1, resp_valid=0, resp_data=0, busy=0.
- Byte update: crc_reg <= TABLE[(crc_reg[7:0] ^ b)] ^ (crc_reg >> 8), logical shift. All values are 32-bit and unsigned.
- FSM states: IDLE, BUSY, RESP.
  - req_ready = (state==IDLE), combinational from the state register only.
  - A request is accepted on an edge where req_valid && req_ready.
- On acceptance at edge N:
  - INIT: crc_reg <= INIT_VAL; resp_data <= 0; go to RESP.
  - BYTE: apply the byte update with req_data0[7:0]; resp_data <= updated crc ^ FINAL_XOR; go to RESP. Latency 1.
  - WORD:
    - Latch req_data0 into a shift register and set cnt=0.
    - Byte 0 (bits [7:0]) is processed at edge N; go to BUSY.
    - Bytes 1..3 are processed at edges N+1..N+3, one per edge, shifting right by 8 and incrementing cnt.
    - At edge N+3: resp_data <= final crc ^ FINAL_XOR; go to RESP. resp_valid is high after N+3 (latency 4).
  - CHECK: resp_data <= {31'b0, crc_reg==RESIDUE}; crc_reg unchanged; go to RESP.
  - READ: resp_data <= crc_reg ^ FINAL_XOR; crc_reg unchanged; go to RESP.
  - Reserved IDs: resp_data <= 0; crc_reg unchanged; go to RESP. The response is still issued.
- RESP state:
  - resp_valid=1.
  - resp_data is held stable until the edge where resp_ready=1; then go to IDLE.
  - A new request is accepted no earlier than the following cycle.
  - resp_valid is never high outside RESP.
- req_data0 and req_function_id are sampled only at acceptance. Changes while BUSY or RESP are ignored.
- req_valid while not ready: no effect. The core must hold the request.
- resp_ready while resp_valid=0: ignored.
- Reset asserted mid-WORD or in RESP: an in-flight op is abandoned, no response is issued, and crc_reg returns to INIT_VAL.
- crc_reg persists across requests. Only INIT and reset reinitialise it.
- CHECK immediately after INIT returns 0, since INIT_VAL != RESIDUE.

Test Plan:
- Known vector, default params:
  - Stimulus: INIT; WORD 0x34333231; WORD 0x38373635; BYTE 0x39; READ.
  - Required: READ and BYTE responses = 0xCBF43926; each WORD resp_valid appears exactly 4 cycles after acceptance; BYTE/READ after 1 cycle.
- Good frame check:
  - Stimulus: after the above, WORD 0xCBF43926; CHECK.
  - Required: WORD resp = 0x2144DF1C; CHECK resp = 0x00000001.
- Corrupt frame:
  - Stimulus: INIT; same 9 bytes; WORD 0xCBF43927; CHECK.
  - Required: CHECK resp = 0x00000000.
- Empty/reserved:
  - INIT; READ -> 0x00000000.
  - CHECK -> 0.
  - function_id 6 -> resp 0, and a following READ is still 0x00000000.
- Backpressure:
  - Stimulus: hold resp_ready=0 for 3 cycles after a BYTE response, with req_valid high and changing data.
  - Required: resp_data stable; req_ready=0; no second request consumed until one cycle after the resp handshake.
- Reset mid-op:
  - Stimulus: assert rst low asynchronously between clock edges at cycle 2 of a WORD.
  - Required: resp_valid=0, req_ready=1, busy=0 immediately; after release, READ -> 0x00000000.

Source files
------------

// File: rtl/crc32_check_cfu.sv
// crc32_check_cfu: stateful CRC-32 CFU with byte-serial table lookup and frame residue check.
module crc32_check_cfu #(
    parameter logic [31:0] POLY      = 32'hEDB88320,
    parameter logic [31:0] INIT_VAL  = 32'hFFFFFFFF,
    parameter logic [31:0] FINAL_XOR = 32'hFFFFFFFF,
    parameter logic [31:0] RESIDUE   = 32'hDEBB20E3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_function_id,
    input  logic [31:0] req_data0,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic        busy
);

    localparam int unsigned CRC_W   = 32;
    localparam int unsigned SHIFT_W = 24;
    localparam int unsigned CNT_W   = 2;
    localparam int unsigned TBL_N   = 256;

    localparam logic [2:0] FN_INIT  = 3'd0;
    localparam logic [2:0] FN_BYTE  = 3'd1;
    localparam logic [2:0] FN_WORD  = 3'd2;
    localparam logic [2:0] FN_CHECK = 3'd3;
    localparam logic [2:0] FN_READ  = 3'd4;

    // Last BUSY byte of a WORD: bytes 1..3 are processed with cnt 0..2
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(2);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // One table entry: eight reflected shift/xor steps of the index
    function automatic logic [CRC_W-1:0] crc_entry(input logic [7:0] idx);
        logic [CRC_W-1:0] c;
        c = CRC_W'(idx);
        for (int k = 0; k < 8; k++) begin
            c = c[0] ? ((c >> 1) ^ POLY) : (c >> 1);
        end
        return c;
    endfunction

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CRC_W-1:0]    r_crc;
    logic [CRC_W-1:0]    w_crc_nxt;
    logic [SHIFT_W-1:0]  r_shift;
    logic [SHIFT_W-1:0]  w_shift_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic [CRC_W-1:0]    r_resp_data;
    logic [CRC_W-1:0]    w_resp_nxt;

    logic [CRC_W-1:0]    w_table [TBL_N];
    logic [7:0]          w_byte;
    logic [7:0]          w_idx;
    logic [CRC_W-1:0]    w_crc_upd;

    // Lookup table built from POLY at elaboration
    for (genvar g = 0; g < TBL_N; g++) begin : g_tbl
        assign w_table[g] = crc_entry(8'(g));
    end

    // Byte source: operand low byte on acceptance, shift register while streaming a WORD
    assign w_byte    = (r_state == S_BUSY) ? r_shift[7:0] : req_data0[7:0];
    assign w_idx     = r_crc[7:0] ^ w_byte;
    assign w_crc_upd = w_table[w_idx] ^ (r_crc >> 8);

    // Handshake and status decoded straight from the state register
    assign req_ready  = (r_state == S_IDLE);
    assign resp_valid = (r_state == S_RESP);
    assign busy       = (r_state != S_IDLE);
    assign resp_data  = r_resp_data;

    // State register and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_crc       <= INIT_VAL;
            r_shift     <= '0;
            r_cnt       <= '0;
            r_resp_data <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_crc       <= w_crc_nxt;
            r_shift     <= w_shift_nxt;
            r_cnt       <= w_cnt_nxt;
            r_resp_data <= w_resp_nxt;
        end
    end

    // Next-state and datapath update for each op
    always_comb begin
        w_state_nxt = r_state;
        w_crc_nxt   = r_crc;
        w_shift_nxt = r_shift;
        w_cnt_nxt   = r_cnt;
        w_resp_nxt  = r_resp_data;

        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_state_nxt = S_RESP;
                    case (req_function_id)
                        FN_INIT: begin
                            w_crc_nxt  = INIT_VAL;
                            w_resp_nxt = '0;
                        end
                        FN_BYTE: begin
                            w_crc_nxt  = w_crc_upd;
                            w_resp_nxt = w_crc_upd ^ FINAL_XOR;
                        end
                        FN_WORD: begin
                            w_crc_nxt   = w_crc_upd;
                            w_shift_nxt = req_data0[31:8];
                            w_cnt_nxt   = '0;
                            w_state_nxt = S_BUSY;
                        end
                        FN_CHECK: begin
                            w_resp_nxt = {31'b0, (r_crc == RESIDUE)};
                        end
                        FN_READ: begin
                            w_resp_nxt = r_crc ^ FINAL_XOR;
                        end
                        default: begin
                            w_resp_nxt = '0;
                        end
                    endcase
                end
            end
            S_BUSY: begin
                w_crc_nxt   = w_crc_upd;
                w_shift_nxt = r_shift >> 8;
                w_cnt_nxt   = r_cnt + CNT_W'(1);
                if (r_cnt == LAST_CNT) begin
                    w_resp_nxt  = w_crc_upd ^ FINAL_XOR;
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule
